// File: rtl/pwm_pkg.sv
// Shared PWM definitions: alignment-mode encoding and the period value loaded at reset.
package pwm_pkg;

   typedef enum logic {
      ALIGN_EDGE   = 1'b0,
      ALIGN_CENTER = 1'b1
   } align_e;

   // Truncated to CTR_LEN at the point of use, so reset always selects the longest period.
   localparam logic [31:0] RST_PERIOD = 32'hFFFF_FFFF;

endpackage

// File: rtl/pwm_prescaler.sv
// Clock divider: tick fires once every prescale+1 enabled clocks; count held at 0 while en is low.
// Latency: tick is combinational from the registered count, so the first tick after enable arrives after prescale clocks.
// Backpressure: none; free-running whenever en is high.
module pwm_prescaler #(
   parameter int PRESC_LEN = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic [PRESC_LEN-1:0] prescale,
   output logic                 tick
);

   logic [PRESC_LEN-1:0] cnt;

   assign tick = en && (cnt == prescale);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (!en || tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + PRESC_LEN'(1);
      end
   end

endmodule

// File: rtl/pwm_bank.sv
// Multi-channel PWM with shadowed period/compare; center alignment built only with PWM_CENTER_ALIGN_EN.
// Latency: pwm and period_tick are registered one clock after the counter state they reflect.
// Backpressure: none; upd is a fire-and-forget strobe, upd_pending flags a shadow not yet applied.
module pwm_bank
   import pwm_pkg::*;
#(
   parameter int NUM_CH    = 4,
   parameter int CTR_LEN   = 8,
   parameter int PRESC_LEN = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      en,
   input  logic [PRESC_LEN-1:0]      prescale,
   input  logic [CTR_LEN-1:0]        period,
   input  logic [NUM_CH*CTR_LEN-1:0] compare,
   input  logic                      upd,
   input  logic                      center,
   output logic [NUM_CH-1:0]         pwm,
   output logic                      period_tick,
   output logic                      upd_pending
);

   localparam logic [CTR_LEN-1:0] CTR_ONE = CTR_LEN'(1);
   localparam logic [CTR_LEN-1:0] PER_RST = RST_PERIOD[CTR_LEN-1:0];

   logic                      tick;
   logic                      boundary;
   logic                      is_center;
   logic                      dn;
   logic                      dn_nxt;
   logic [CTR_LEN-1:0]        ctr;
   logic [CTR_LEN-1:0]        ctr_nxt;
   logic [CTR_LEN-1:0]        mirror;
   logic [CTR_LEN-1:0]        cmp_i;
   logic [CTR_LEN-1:0]        per_act;
   logic [CTR_LEN-1:0]        per_shd;
   logic [NUM_CH*CTR_LEN-1:0] cmp_act;
   logic [NUM_CH*CTR_LEN-1:0] cmp_shd;
   logic [NUM_CH-1:0]         pwm_nxt;

   pwm_prescaler #(
      .PRESC_LEN (PRESC_LEN)
   ) u_presc (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (en),
      .prescale (prescale),
      .tick     (tick)
   );

`ifdef PWM_CENTER_ALIGN_EN
   align_e mode;

   assign is_center = (mode == ALIGN_CENTER);

   // Mode only switches where the count restarts: at a boundary or while idle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mode <= ALIGN_EDGE;
         dn   <= 1'b0;
      end else begin
         dn <= en ? dn_nxt : 1'b0;
         if (!en || boundary) begin
            mode <= center ? ALIGN_CENTER : ALIGN_EDGE;
         end
      end
   end
`else
   logic unused_bits;

   assign unused_bits = ^{center, dn_nxt};
   assign is_center   = 1'b0;
   assign dn          = 1'b0;
`endif

   always_comb begin
      ctr_nxt  = ctr;
      dn_nxt   = dn;
      boundary = 1'b0;
      if (is_center) begin
         // The fold at the peak is not a boundary; the period ends on the last down-step.
         boundary = tick && ((per_act == '0) ||
                             ((ctr == CTR_ONE) && (dn || (per_act == CTR_ONE))));
         if (boundary) begin
            ctr_nxt = '0;
            dn_nxt  = 1'b0;
         end else if (tick) begin
            if (dn || (ctr == per_act)) begin
               ctr_nxt = ctr - CTR_ONE;
               dn_nxt  = 1'b1;
            end else begin
               ctr_nxt = ctr + CTR_ONE;
            end
         end
      end else begin
         boundary = tick && (ctr == per_act);
         if (boundary) begin
            ctr_nxt = '0;
         end else if (tick) begin
            ctr_nxt = ctr + CTR_ONE;
         end
      end
   end

   // Center mode compares against the distance from the peak so the pulse straddles it.
   assign mirror = per_act - ctr;

   always_comb begin
      pwm_nxt = '0;
      cmp_i   = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cmp_i = cmp_act[i*CTR_LEN +: CTR_LEN];
         if (is_center) begin
            pwm_nxt[i] = dn ? (cmp_i >= mirror) : (cmp_i > mirror);
         end else begin
            pwm_nxt[i] = (cmp_i > ctr);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ctr         <= '0;
         pwm         <= '0;
         period_tick <= 1'b0;
         upd_pending <= 1'b0;
         per_act     <= PER_RST;
         per_shd     <= PER_RST;
         cmp_act     <= '0;
         cmp_shd     <= '0;
      end else begin
         ctr         <= en ? ctr_nxt : '0;
         pwm         <= en ? pwm_nxt : '0;
         period_tick <= boundary;
         if (upd) begin
            per_shd <= period;
            cmp_shd <= compare;
         end
         // An idle bank or a coinciding boundary has nothing to wait for.
         if (upd && (boundary || !en)) begin
            per_act     <= period;
            cmp_act     <= compare;
            upd_pending <= 1'b0;
         end else if (upd) begin
            upd_pending <= 1'b1;
         end else if (boundary) begin
            per_act     <= per_shd;
            cmp_act     <= cmp_shd;
            upd_pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_pwm_bank.sv
// Self-checking bench for pwm_bank: table of steady-state duty vectors plus update and reset sequences.
module tb_pwm_bank;

   localparam int NUM_CH    = 4;
   localparam int CTR_LEN   = 8;
   localparam int PRESC_LEN = 8;

   typedef struct {
      logic [7:0]       ps;
      logic [7:0]       per;
      logic [31:0]      cmp;
      int               len;
      logic [3:0][15:0] hi;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        upd = 1'b0;
   logic        center = 1'b0;
   logic [7:0]  prescale = '0;
   logic [7:0]  period = '0;
   logic [31:0] compare = '0;
   logic [3:0]  pwm;
   logic        period_tick;
   logic        upd_pending;

   int   errors = 0;
   int   checks = 0;
   vec_t vecs [5];
   vec_t sb [$];

   always #5 clk = ~clk;

   pwm_bank #(
      .NUM_CH    (NUM_CH),
      .CTR_LEN   (CTR_LEN),
      .PRESC_LEN (PRESC_LEN)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .prescale    (prescale),
      .period      (period),
      .compare     (compare),
      .upd         (upd),
      .center      (center),
      .pwm         (pwm),
      .period_tick (period_tick),
      .upd_pending (upd_pending)
   );

   task automatic check(input string name, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Idle the bank, write the settings straight into the active registers, then run.
   task automatic load(input logic [7:0] ps, input logic [7:0] per, input logic [31:0] cmp);
      @(negedge clk);
      en       = 1'b0;
      prescale = ps;
      period   = per;
      compare  = cmp;
      upd      = 1'b1;
      @(negedge clk);
      upd = 1'b0;
      check("idle_upd_pending", upd_pending, 0);
      en = 1'b1;
   endtask

   // Sample until the next period_tick; optional upd strobes at sample numbers ua/ub.
   task automatic run_period(input int ua, input logic [31:0] ca, input int ub, input logic [31:0] cb,
                             output int len, output int hi0, output bit pend_seen, output bit pend_end);
      len = -1; hi0 = 0; pend_seen = 1'b0; pend_end = 1'b0;
      for (int n = 1; n <= 2000; n++) begin
         @(negedge clk);
         if (pwm[0]) hi0++;
         if (upd_pending) pend_seen = 1'b1;
         upd = 1'b0;
         if (n == ua) begin compare = ca; upd = 1'b1; end
         if (n == ub) begin compare = cb; upd = 1'b1; end
         if (period_tick) begin
            len = n;
            pend_end = upd_pending;
            break;
         end
      end
   endtask

   initial begin
      vec_t v;
      int   len, hi0, nt;
      bit   pseen, pend;
      int   hi [4];

      //            ps     per     compare {ch3,ch2,ch1,ch0}    len  high clocks {ch3..ch0}
      vecs[0] = '{8'd0, 8'd9,   {8'd10, 8'd9, 8'd3, 8'd0},    10,  {16'd10, 16'd9, 16'd3, 16'd0}};
      vecs[1] = '{8'd2, 8'd3,   {8'd1, 8'd4, 8'd0, 8'd2},     12,  {16'd3, 16'd12, 16'd0, 16'd6}};
      vecs[2] = '{8'd1, 8'd0,   {8'd0, 8'd5, 8'd1, 8'd0},     2,   {16'd0, 16'd2, 16'd2, 16'd0}};
      vecs[3] = '{8'd0, 8'd255, {8'd254, 8'd1, 8'd255, 8'd128}, 256, {16'd254, 16'd1, 16'd255, 16'd128}};
      vecs[4] = '{8'd0, 8'd4,   {8'd1, 8'd4, 8'd5, 8'd2},     5,   {16'd1, 16'd4, 16'd5, 16'd2}};

      #1;
      check("reset_pwm", pwm, 0);
      check("reset_period_tick", period_tick, 0);
      check("reset_upd_pending", upd_pending, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         load(vecs[i].ps, vecs[i].per, vecs[i].cmp);
         sb.push_back(vecs[i]);
         run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
         check($sformatf("v%0d_sync", i), (len > 0) ? 1 : 0, 1);
         for (int c = 0; c < 4; c++) hi[c] = 0;
         nt = 0;
         for (int k = 0; k < 2 * vecs[i].len; k++) begin
            @(negedge clk);
            for (int c = 0; c < 4; c++) if (pwm[c]) hi[c]++;
            if (period_tick) nt++;
         end
         v = sb.pop_front();
         for (int c = 0; c < 4; c++)
            check($sformatf("v%0d_ch%0d_high", i, c), hi[c], 2 * int'(v.hi[c]));
         check($sformatf("v%0d_ticks", i), nt, 2);
      end

      // Mid-period update, update on the boundary, and last-write-wins.
      load(8'd0, 8'd9, 32'h3);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("first_period_len", len, 10);
      run_period(4, 32'h7, -1, '0, len, hi0, pseen, pend);
      check("mid_upd_old_duty", hi0, 3);
      check("mid_upd_pending_seen", pseen, 1);
      check("mid_upd_pending_cleared", pend, 0);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("mid_upd_new_duty", hi0, 7);
      check("mid_upd_len", len, 10);
      run_period(9, 32'h5, -1, '0, len, hi0, pseen, pend);
      check("bnd_upd_old_duty", hi0, 7);
      check("bnd_upd_no_pending", pseen, 0);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("bnd_upd_new_duty", hi0, 5);
      check("bnd_upd_no_pending_after", pseen, 0);
      run_period(2, 32'h1, 5, 32'h6, len, hi0, pseen, pend);
      check("double_upd_old_duty", hi0, 5);
      check("double_upd_pending_seen", pseen, 1);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("double_upd_last_wins", hi0, 6);

      // Asynchronous reset while pwm and period_tick are both high.
      load(8'd0, 8'd9, 32'hA);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("pre_reset_pwm0", pwm[0], 1);
      check("pre_reset_tick", period_tick, 1);
      #1 rst_n = 1'b0;
      #1;
      check("async_reset_pwm", pwm, 0);
      check("async_reset_tick", period_tick, 0);
      check("async_reset_pending", upd_pending, 0);
      @(negedge clk);
      rst_n = 1'b1;
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("post_reset_period_len", len, 256);
      check("post_reset_cmp_cleared", hi0, 0);

`ifdef PWM_CENTER_ALIGN_EN
      center = 1'b1;
      load(8'd0, 8'd4, 32'h2);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      run_period(-1, '0, -1, '0, len, hi0, pseen, pend);
      check("center_period_len", len, 8);
      check("center_ch0_high", hi0, 4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
